// File: rtl/led_bank_arbiter.sv
`timescale 1ns/1ps
// Round-robin owner of the 8-LED bank: registered one-hot GNT, LEDs follow the owner's DATA one cycle later,
// with a hold quantum per owner and an all-dark gap between owners. LED_ARB_IDLE_HEARTBEAT_EN blinks LED7 while idle.
module led_bank_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 12_000_000,
    parameter int GAP_CYCLES  = 1_200_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [8*NREQ-1:0] DATA,
    output logic [NREQ-1:0]   GNT,
    output logic [2:0]        OWNER,
    output logic              BUSY,
    output logic              LED0,
    output logic              LED1,
    output logic              LED2,
    output logic              LED3,
    output logic              LED4,
    output logic              LED5,
    output logic              LED6,
    output logic              LED7
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_FULL = HW'(HOLD_CYCLES);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [2:0]      r_owner;
    logic [2:0]      r_rr;
    logic            r_busy;
    logic [7:0]      r_led;
    logic [HW-1:0]   r_hold;
    logic [GW-1:0]   r_gap;
`ifdef LED_ARB_IDLE_HEARTBEAT_EN
    logic [HW-1:0]   r_hb;
`endif

    logic            w_win_vld;
    logic [2:0]      w_win_idx;
    logic [NREQ-1:0] w_win_mask;
    logic [NREQ-1:0] w_own_mask;
    logic [7:0]      w_own_dat;
    logic            w_own_req;
    logic            w_other_req;
    logic            w_leave;
    int              w_dist;
    int              w_best;

    // Winner is the requester at the smallest rotational distance above the rr pointer.
    always_comb begin
        w_win_vld  = 1'b0;
        w_win_idx  = '0;
        w_win_mask = '0;
        w_best     = NREQ;
        w_dist     = 0;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = (j - int'(r_rr) + NREQ) % NREQ;
            if (REQ[j] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_win_idx = 3'(j);
                w_win_vld = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            w_win_mask[j] = (w_win_idx == 3'(j));
        end
    end

    always_comb begin
        w_own_mask = '0;
        w_own_dat  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (r_owner == 3'(j)) begin
                w_own_mask[j] = 1'b1;
                w_own_dat     = DATA[8*j +: 8];
            end
        end
    end

    assign w_own_req   = |(REQ & w_own_mask);
    assign w_other_req = |(REQ & ~w_own_mask);
    // Voluntary release wins over quantum expiry; expiry only yields when someone else waits.
    assign w_leave     = !w_own_req || ((r_hold == HOLD_LAST) && w_other_req);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_rr    <= '0;
            r_busy  <= 1'b0;
            r_led   <= '0;
            r_hold  <= '0;
            r_gap   <= '0;
`ifdef LED_ARB_IDLE_HEARTBEAT_EN
            r_hb    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_state <= S_GRANT;
                        r_gnt   <= w_win_mask;
                        r_owner <= w_win_idx;
                        r_busy  <= 1'b1;
                        r_hold  <= '0;
                        r_led   <= '0;
                    end else begin
`ifdef LED_ARB_IDLE_HEARTBEAT_EN
                        if (r_hb == HOLD_LAST) begin
                            r_led <= {~r_led[7], 7'b0};
                            r_hb  <= '0;
                        end else begin
                            r_led <= {r_led[7], 7'b0};
                            r_hb  <= r_hb + 1'b1;
                        end
`else
                        r_led <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    if (w_leave) begin
                        r_state <= S_GAP;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_led   <= '0;
                        r_gap   <= '0;
                        r_hold  <= '0;
                        r_rr    <= (r_owner == 3'(NREQ - 1)) ? 3'd0 : r_owner + 3'd1;
                    end else begin
                        r_led <= w_own_dat;
                        if (r_hold == HOLD_LAST) begin
                            r_hold <= '0;
                        end else if (r_hold != HOLD_FULL) begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    r_led <= '0;
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_gap   <= '0;
`ifdef LED_ARB_IDLE_HEARTBEAT_EN
                        r_hb    <= '0;
`endif
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_led   <= '0;
                end
            endcase
        end
    end

    assign GNT   = r_gnt;
    assign OWNER = r_owner;
    assign BUSY  = r_busy;
    assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = r_led;
endmodule

// File: tb/tb_led_bank_arbiter.sv
`timescale 1ns/1ps
// Bench for led_bank_arbiter: table vectors, hand sequences for multi-cycle corners, random run vs a reference model.
module tb_led_bank_arbiter;
    localparam int NREQ = 4;
    localparam int HOLD = 8;
    localparam int GAP  = 2;
`ifdef LED_ARB_IDLE_HEARTBEAT_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [2:0]  owner;
    logic        busy;
    logic        led0, led1, led2, led3, led4, led5, led6, led7;
    logic [7:0]  leds;

    assign leds = {led7, led6, led5, led4, led3, led2, led1, led0};

    led_bank_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .DATA(data),
        .GNT(gnt), .OWNER(owner), .BUSY(busy),
        .LED0(led0), .LED1(led1), .LED2(led2), .LED3(led3),
        .LED4(led4), .LED5(led5), .LED6(led6), .LED7(led7)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner (-1 = none), cycles used in the current quantum, gap cycles left.
    int         m_owner = -1;
    int         m_qused = 0;
    int         m_gap   = 0;
    int         m_ptr   = 0;
    int         m_hb    = 0;
    logic [7:0] m_led   = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] rq, input logic [31:0] d);
        bit found;
        int idx;
        if (r) begin
            m_owner = -1; m_gap = 0; m_ptr = 0; m_led = 8'h00; m_hb = 0; m_qused = 0;
        end else if (m_owner >= 0) begin
            m_qused++;
            if (!rq[m_owner] || (m_qused == HOLD && (rq & ~(4'b0001 << m_owner)) != 4'b0)) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_gap   = GAP;
                m_led   = 8'h00;
            end else begin
                if (m_qused == HOLD) m_qused = 0;
                m_led = d[8*m_owner +: 8];
            end
        end else if (m_gap > 0) begin
            m_gap--;
            m_led = 8'h00;
            if (m_gap == 0) m_hb = 0;
        end else if (rq != 4'b0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && rq[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                end
            end
            m_qused = 0;
            m_led   = 8'h00;
        end else if (HB) begin
            m_hb++;
            if (m_hb == HOLD) begin
                m_led = {~m_led[7], 7'b0};
                m_hb  = 0;
            end
        end else begin
            m_led = 8'h00;
        end
    endtask

    task automatic cmp_model(input string tag);
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
        chk({tag, ".led"}, 32'(leds), 32'(m_led));
        if (m_owner >= 0) chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
    endtask

    task automatic tick(input logic r, input logic [3:0] rq, input logic [31:0] d);
        rst  = r;
        req  = rq;
        data = d;
        @(posedge clk);
        #1;
        model_step(r, rq, d);
    endtask

    function automatic int onehot_idx(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic        busy;
        logic [7:0]  led;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #(20 * 50000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int owners[$];
        int runs[$];
        int darks[$];
        int run_len, dark_len, cyc;
        logic [3:0] prev_g, rq;
        logic lit;
        logic [31:0] rr_data;

        rst = 1'b1; req = 4'b0; data = 32'h0;

        // Reset with all requests asserted, then a lone requester 2 that keeps its grant past one quantum.
        for (int i = 0; i < 3; i++)  vecs[i] = '{1'b1, 4'hF, 32'h44A52211, 4'h0, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 4'b0100, 32'h44A52211, 4'b0100, 1'b1, 8'h00};
        for (int i = 4; i < 14; i++) vecs[i] = '{1'b0, 4'b0100, 32'h44A52211, 4'b0100, 1'b1, 8'hA5};

        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].rst, vecs[i].req, vecs[i].data);
            chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d.led", i), 32'(leds), 32'(vecs[i].led));
            if (vecs[i].busy) chk($sformatf("vec%0d.owner", i), 32'(owner), 32'd2);
        end

        // Round robin with everyone requesting.
        rr_data = 32'h44332211;
        tick(1'b1, 4'hF, rr_data);
        prev_g = 4'b0; run_len = 0; dark_len = 0; lit = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick(1'b0, 4'hF, rr_data);
            cmp_model("rr");
            if (gnt != 4'b0 && prev_g == 4'b0) begin
                owners.push_back(onehot_idx(gnt));
                run_len = 0;
            end
            if (gnt != 4'b0) run_len++;
            if (gnt == 4'b0 && prev_g != 4'b0) runs.push_back(run_len);
            if (leds == 8'h00) dark_len++;
            else begin
                if (lit && dark_len > 0) darks.push_back(dark_len);
                lit = 1'b1;
                dark_len = 0;
            end
            prev_g = gnt;
        end
        chk("rr.n_owners", 32'(owners.size() >= 5), 32'd1);
        if (owners.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("rr.owner%0d", i), 32'(owners[i]), 32'(i % 4));
        end
        chk("rr.n_runs", 32'(runs.size() >= 4), 32'd1);
        if (runs.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("rr.run%0d", i), 32'(runs[i]), 32'(HOLD));
        end
        chk("rr.n_darks", 32'(darks.size() >= 3), 32'd1);
        if (darks.size() >= 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("rr.dark%0d", i), 32'(darks[i] >= GAP), 32'd1);
        end

        // Early release by owner 1 while requester 3 waits.
        tick(1'b1, 4'b0000, rr_data);
        tick(1'b0, 4'b1010, rr_data);
        chk("er.gnt1", 32'(gnt), 32'b0010);
        tick(1'b0, 4'b1010, rr_data);
        tick(1'b0, 4'b1010, rr_data);
        cmp_model("er");
        tick(1'b0, 4'b1000, rr_data);
        chk("er.gap1.gnt", 32'(gnt), 32'b0000);
        chk("er.gap1.led", 32'(leds), 32'h00);
        tick(1'b0, 4'b1000, rr_data);
        chk("er.gap2.gnt", 32'(gnt), 32'b0000);
        tick(1'b0, 4'b1000, rr_data);
        chk("er.idle.gnt", 32'(gnt), 32'b0000);
        tick(1'b0, 4'b1000, rr_data);
        chk("er.gnt3", 32'(gnt), 32'b1000);
        cmp_model("er");

        // Reset while owner 2 holds the bank.
        tick(1'b1, 4'hF, rr_data);
        cyc = 0;
        while (gnt != 4'b0100 && cyc < 60) begin
            tick(1'b0, 4'hF, rr_data);
            cyc++;
        end
        chk("mr.reach_owner2", 32'(gnt), 32'b0100);
        tick(1'b0, 4'hF, rr_data);
        tick(1'b1, 4'hF, rr_data);
        chk("mr.gnt", 32'(gnt), 32'b0000);
        chk("mr.busy", 32'(busy), 32'd0);
        chk("mr.led", 32'(leds), 32'h00);
        tick(1'b0, 4'hF, rr_data);
        chk("mr.regrant", 32'(gnt), 32'b0001);
        chk("mr.owner", 32'(owner), 32'd0);

        // Idle with no requests: dark, or LED7 heartbeat when enabled.
        tick(1'b1, 4'b0000, rr_data);
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 4'b0000, rr_data);
            chk($sformatf("idle.led%0d", k), 32'(leds),
                32'((HB && ((k / HOLD) % 2 == 1)) ? 8'h80 : 8'h00));
        end

        // Random traffic against the reference model.
        tick(1'b1, 4'b0000, 32'h0);
        rq = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (rq[b]) begin
                    if ($urandom_range(0, 19) == 0) rq[b] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    rq[b] = 1'b1;
                end
            end
            tick(($urandom_range(0, 149) == 0), rq, $urandom);
            cmp_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
